// File: rtl/ls_usb_receiver.sv
// Low-speed USB receive path: line synchronizer, oversampled bit recovery, NRZI decode,
// SYNC detection, bit de-stuffing, LSB-first byte assembly and EOP detection.
module ls_usb_receiver #(
    parameter int unsigned OVERSAMPLE     = 8,
    parameter int unsigned SYNC_MIN_ZEROS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp_in,
    input  logic       dm_in,
    input  logic       rx_enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sop,
    output logic       eop,
    output logic       stuff_err,
    output logic       align_err,
    output logic       rx_active
);

    localparam int unsigned PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] SampleAt = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PhaseMax = PW'(OVERSAMPLE - 1);
    localparam logic [2:0]    MinZeros = 3'(SYNC_MIN_ZEROS);

    // Line states encoded as {dp, dm}
    localparam logic [1:0] LineJ   = 2'b01;
    localparam logic [1:0] LineK   = 2'b10;
    localparam logic [1:0] LineSe0 = 2'b00;

    typedef enum logic [2:0] {StIdle, StSync, StData, StEop, StAbort} state_e;

    state_e      state_q, state_d;
    logic        dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q;
    logic [1:0]  line, line_last_q;
    logic [PW-1:0] phase_q, phase;
    logic        sample, nrzi_bit;
    logic [1:0]  prev_q, prev_d;
    logic [2:0]  zero_cnt_q, zero_cnt_d;
    logic [2:0]  ones_cnt_q, ones_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        se0_seen_q, se0_seen_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_d, sop_d, eop_d, stuff_err_d, align_err_d;
    logic        rx_active_q, rx_active_d;
    logic        data_valid_q, sop_q, eop_q, stuff_err_q, align_err_q;

    // SE1 is folded into SE0
    assign line     = (dp_sync_q & dm_sync_q) ? LineSe0 : {dp_sync_q, dm_sync_q};
    assign phase    = (line != line_last_q) ? '0 : phase_q;
    assign sample   = (phase == SampleAt);
    assign nrzi_bit = (line == prev_q);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        zero_cnt_d   = zero_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        se0_seen_d   = se0_seen_q;
        data_out_d   = data_out_q;
        rx_active_d  = rx_active_q;
        data_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        stuff_err_d  = 1'b0;
        align_err_d  = 1'b0;

        if (sample) begin
            prev_d = line;
        end

        if (!rx_enable) begin
            state_d     = StIdle;
            prev_d      = LineJ;
            rx_active_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    prev_d = LineJ;
                    if (line == LineK && line_last_q == LineJ) begin
                        state_d    = StSync;
                        zero_cnt_d = '0;
                    end
                end
                StSync: begin
                    if (sample) begin
                        if (line == LineSe0) begin
                            state_d = StIdle;
                        end else if (!nrzi_bit) begin
                            zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
                        end else if (zero_cnt_q >= MinZeros) begin
                            state_d     = StData;
                            sop_d       = 1'b1;
                            rx_active_d = 1'b1;
                            bit_cnt_d   = '0;
                            // The SYNC-terminating 1 counts toward the stuffing run
                            ones_cnt_d  = 3'd1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StData: begin
                    if (sample) begin
                        if (line == LineSe0) begin
                            state_d = StEop;
                        end else if (ones_cnt_q == 3'd6 && !nrzi_bit) begin
                            ones_cnt_d = '0;
                        end else if (ones_cnt_q == 3'd6) begin
                            stuff_err_d = 1'b1;
                            rx_active_d = 1'b0;
                            se0_seen_d  = 1'b0;
                            state_d     = StAbort;
                        end else begin
                            shift_d    = {nrzi_bit, shift_q[7:1]};
                            ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_d    = '0;
                                data_out_d   = {nrzi_bit, shift_q[7:1]};
                                data_valid_d = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                    end
                end
                StEop: begin
                    if (sample && line != LineSe0) begin
                        eop_d       = 1'b1;
                        align_err_d = (line == LineK) || (bit_cnt_q != 3'd0);
                        rx_active_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                StAbort: begin
                    if (sample) begin
                        if (line == LineSe0) begin
                            se0_seen_d = 1'b1;
                        end else if (line == LineJ && se0_seen_q) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_meta_q    <= 1'b0;
            dp_sync_q    <= 1'b0;
            dm_meta_q    <= 1'b1;
            dm_sync_q    <= 1'b1;
            line_last_q  <= LineJ;
            phase_q      <= '0;
            state_q      <= StIdle;
            prev_q       <= LineJ;
            zero_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            se0_seen_q   <= 1'b0;
            data_out_q   <= '0;
            rx_active_q  <= 1'b0;
            data_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            dp_meta_q    <= dp_in;
            dp_sync_q    <= dp_meta_q;
            dm_meta_q    <= dm_in;
            dm_sync_q    <= dm_meta_q;
            line_last_q  <= line;
            phase_q      <= (phase == PhaseMax) ? '0 : phase + 1'b1;
            state_q      <= state_d;
            prev_q       <= prev_d;
            zero_cnt_q   <= zero_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            se0_seen_q   <= se0_seen_d;
            data_out_q   <= data_out_d;
            rx_active_q  <= rx_active_d;
            data_valid_q <= data_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign sop        = sop_q;
    assign eop        = eop_q;
    assign stuff_err  = stuff_err_q;
    assign align_err  = align_err_q;
    assign rx_active  = rx_active_q;

endmodule

// File: tb/tb_ls_usb_receiver.sv
// Directed bench for ls_usb_receiver: NRZI/stuffing line encoder plus strobe counters.
module tb_ls_usb_receiver;

    localparam int OS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dp_in = 1'b0;
    logic       dm_in = 1'b1;
    logic       rx_enable = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, sop, eop, stuff_err, align_err, rx_active;

    ls_usb_receiver #(
        .OVERSAMPLE    (OS),
        .SYNC_MIN_ZEROS(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dp_in     (dp_in),
        .dm_in     (dm_in),
        .rx_enable (rx_enable),
        .data_out  (data_out),
        .data_valid(data_valid),
        .sop       (sop),
        .eop       (eop),
        .stuff_err (stuff_err),
        .align_err (align_err),
        .rx_active (rx_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int n_sop, n_eop, n_dv, n_stuff, n_align, n_both;
    logic [7:0] got_bytes[$];

    logic cur_k;
    int   ones_run;
    logic jitter = 1'b0;
    logic jflip  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (sop) n_sop++;
            if (eop) n_eop++;
            if (stuff_err) n_stuff++;
            if (align_err) n_align++;
            if (eop && align_err) n_both++;
            if (data_valid) begin
                n_dv++;
                got_bytes.push_back(data_out);
            end
        end
    end

    // Called on a negedge, well away from the monitor
    task automatic clear_counts();
        n_sop = 0; n_eop = 0; n_dv = 0; n_stuff = 0; n_align = 0; n_both = 0;
        got_bytes.delete();
    endtask

    task automatic drive_line(input logic dp, input logic dm, input int n);
        dp_in = dp;
        dm_in = dm;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_raw_bit(input logic b);
        int n;
        n = OS;
        if (jitter) begin
            n = jflip ? OS + 1 : OS - 1;
            jflip = ~jflip;
        end
        if (!b) cur_k = ~cur_k;
        drive_line(cur_k, ~cur_k, n);
    endtask

    task automatic send_bit(input logic b);
        send_raw_bit(b);
        ones_run = b ? ones_run + 1 : 0;
        if (ones_run == 6) begin
            send_raw_bit(1'b0);
            ones_run = 0;
        end
    endtask

    task automatic send_sync();
        cur_k = 1'b0;
        for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
        send_raw_bit(1'b1);
        ones_run = 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop();
        drive_line(1'b0, 1'b0, 2 * OS);
        drive_line(1'b0, 1'b1, 2 * OS);
        cur_k = 1'b0;
        drive_line(1'b0, 1'b1, 2 * OS);
    endtask

    function automatic logic [31:0] byte_at(input int i);
        return (i < got_bytes.size()) ? {24'h0, got_bytes[i]} : 32'hFFFF_FFFF;
    endfunction

    logic [7:0] jbytes[8] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'hC3};

    initial begin
        clear_counts();
        repeat (4) @(negedge clk);
        check("reset_outputs", {25'h0, data_out, data_valid, sop, eop, stuff_err, align_err,
                                rx_active}, 32'h0);
        rst = 1'b0;
        drive_line(1'b0, 1'b1, 20);

        // Basic packet 0xA5
        clear_counts();
        send_sync();
        send_byte(8'hA5);
        send_eop();
        check("t1_sop", n_sop, 1);
        check("t1_dv", n_dv, 1);
        check("t1_byte", byte_at(0), 32'hA5);
        check("t1_eop", n_eop, 1);
        check("t1_align", n_align, 0);
        check("t1_rx_active", {31'h0, rx_active}, 0);
        check("t1_data_hold", {24'h0, data_out}, 32'hA5);

        // 0xFF 0xFF with stuffed zeros
        clear_counts();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_eop();
        check("t2_dv", n_dv, 2);
        check("t2_byte0", byte_at(0), 32'hFF);
        check("t2_byte1", byte_at(1), 32'hFF);
        check("t2_stuff", n_stuff, 0);
        check("t2_eop", n_eop, 1);

        // Seven consecutive ones (SYNC 1 plus six data ones) without stuffing
        clear_counts();
        send_sync();
        for (int i = 0; i < 6; i++) send_raw_bit(1'b1);
        send_eop();
        check("t3_sop", n_sop, 1);
        check("t3_stuff", n_stuff, 1);
        check("t3_dv", n_dv, 0);
        check("t3_eop", n_eop, 0);
        check("t3_rx_active", {31'h0, rx_active}, 0);

        // 0x3C plus three extra bits
        clear_counts();
        send_sync();
        send_byte(8'h3C);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop();
        check("t4_sop", n_sop, 1);
        check("t4_dv", n_dv, 1);
        check("t4_byte", byte_at(0), 32'h3C);
        check("t4_eop", n_eop, 1);
        check("t4_eop_align_same", n_both, 1);
        check("t4_align", n_align, 1);

        // Jittered bit periods over 8 bytes
        clear_counts();
        jitter = 1'b1;
        send_sync();
        for (int i = 0; i < 8; i++) send_byte(jbytes[i]);
        jitter = 1'b0;
        send_eop();
        check("t5_dv", n_dv, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t5_byte%0d", i), byte_at(i), {24'h0, jbytes[i]});
        check("t5_eop", n_eop, 1);
        check("t5_align", n_align, 0);

        // Receiver disabled for a whole packet
        clear_counts();
        rx_enable = 1'b0;
        send_sync();
        send_byte(8'hA5);
        send_eop();
        rx_enable = 1'b1;
        drive_line(1'b0, 1'b1, 10);
        check("t5b_strobes", n_sop + n_dv + n_eop + n_stuff + n_align, 0);

        // Reset mid-byte, then a fresh packet
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        drive_line(1'b0, 1'b1, 40);
        check("t6_no_stale", n_sop + n_dv + n_eop + n_stuff + n_align, 0);
        check("t6_rx_active_after_rst", {31'h0, rx_active}, 0);
        send_sync();
        send_byte(8'h5A);
        send_eop();
        check("t6_sop", n_sop, 1);
        check("t6_dv", n_dv, 1);
        check("t6_byte", byte_at(0), 32'h5A);
        check("t6_eop", n_eop, 1);
        check("t6_align", n_align, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
